array_frame_loader: RTL

//  Sequences a serial element stream into one flattened ROWS*COLS*BIT_WIDTH frame bus
//  for the 1D->3D array unpacking stage.

---
 rtl/array_frame_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/array_frame_loader.sv
// -----------------------------------------------------------------------------
// array_frame_loader
//
// Purpose:
//   Collects a serial stream of array elements (one per cycle, valid/ready)
//   into a flattened ROWS*COLS*BIT_WIDTH frame bus for the 1D->3D unpacking
//   stage. The completed frame is held stable until the consumer accepts it.
//   The buffer is then cleared and the loader refills.
//
// Parameters:
//   BIT_WIDTH  bits per array element
//   ROWS       array rows    (i index)
//   COLS       array columns (j index)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_data      incoming element
//   in_valid     in_data valid
//   in_last      final element of a (possibly short) frame
//   in_ready     loader accepts an element this cycle (combinational)
//   frame_out    packed frame; element (i,j) at [(j*ROWS+i)*BIT_WIDTH +: BIT_WIDTH]
//   frame_valid  frame_out complete and stable
//   frame_ready  consumer accepts the frame
//   short_frame  held frame was closed early by in_last
//   row_idx      row of the next slot to be written
//   col_idx      column of the next slot to be written
//
// Configuration:
//   ARRAY_LOADER_ROW_MAJOR_EN - when defined, the producer stream is row-major
//   (col_idx advances first). Slot placement in frame_out stays column-major,
//   so the block transposes the stream. The default build uses column-major
//   traversal.
// -----------------------------------------------------------------------------
module array_frame_loader #(
    parameter  int BIT_WIDTH = 4,
    parameter  int ROWS      = 8,
    parameter  int COLS      = 8,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int FW        = ROWS * COLS * BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [FW-1:0]        frame_out,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 short_frame,
    output logic [RW-1:0]        row_idx,
    output logic [CW-1:0]        col_idx
);

    localparam logic [0:0]    ST_FILL = 1'b0;
    localparam logic [0:0]    ST_HOLD = 1'b1;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [0:0]    state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          frame_valid_q, frame_valid_d;
    logic          short_frame_q, short_frame_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    logic          accept_s;
    logic          last_slot_s;
    logic [RW-1:0] row_next_s;
    logic [CW-1:0] col_next_s;
    int            slot_s;

    // Producer handshake: ready only while filling and out of reset.
    always_comb begin
        in_ready = !rst && (state_q == ST_FILL);
        accept_s = in_valid && in_ready;
    end

    // Position bookkeeping: slot index in frame_out and the next traversal position.
    always_comb begin
        last_slot_s = (row_q == ROW_MAX) && (col_q == COL_MAX);
        // Placement is always column-major, independent of stream order.
        slot_s      = (int'(col_q) * ROWS) + int'(row_q);
`ifdef ARRAY_LOADER_ROW_MAJOR_EN
        if (col_q == COL_MAX) begin
            col_next_s = '0;
            row_next_s = row_q + RW'(1);
        end else begin
            col_next_s = col_q + CW'(1);
            row_next_s = row_q;
        end
`else
        if (row_q == ROW_MAX) begin
            row_next_s = '0;
            col_next_s = col_q + CW'(1);
        end else begin
            row_next_s = row_q + RW'(1);
            col_next_s = col_q;
        end
`endif
    end

    // Next-state logic for the fill/hold sequencer and the frame buffer.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        short_frame_d = short_frame_q;
        row_d         = row_q;
        col_d         = col_q;

        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    // Constant-index write loop keeps the slot decode free of
                    // variable part-selects.
                    for (int s = 0; s < ROWS * COLS; s++) begin
                        if (s == slot_s) begin
                            frame_d[s*BIT_WIDTH +: BIT_WIDTH] = in_data;
                        end else begin
                            frame_d[s*BIT_WIDTH +: BIT_WIDTH] = frame_q[s*BIT_WIDTH +: BIT_WIDTH];
                        end
                    end
                    if (last_slot_s || in_last) begin
                        // Indices stay on the closing slot for the whole hold.
                        state_d       = ST_HOLD;
                        frame_valid_d = 1'b1;
                        short_frame_d = !last_slot_s;
                    end else begin
                        row_d = row_next_s;
                        col_d = col_next_s;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_HOLD: begin
                // frame_valid is always high here, so frame_ready alone completes the handoff.
                if (frame_ready) begin
                    state_d       = ST_FILL;
                    frame_d       = '0;
                    frame_valid_d = 1'b0;
                    short_frame_d = 1'b0;
                    row_d         = '0;
                    col_d         = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d       = ST_FILL;
                frame_d       = '0;
                frame_valid_d = 1'b0;
                short_frame_d = 1'b0;
                row_d         = '0;
                col_d         = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            short_frame_q <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            short_frame_q <= short_frame_d;
            row_q         <= row_d;
            col_q         <= col_d;
        end
    end

    assign frame_out   = frame_q;
    assign frame_valid = frame_valid_q;
    assign short_frame = short_frame_q;
    assign row_idx     = row_q;
    assign col_idx     = col_q;

endmodule
